// File: rtl/cam_frame_tx.sv
// Replays a stored RGB444 frame from the DP RAM as an OV7670-style byte stream.
// Latency: CAM_vsync rises one edge after en; first href follows VSYNC_W+V_BP cycles later.
// No backpressure: the stream runs at a fixed raster rate once a frame is started.
module cam_frame_tx #(
  parameter int AW      = 15,
  parameter int DW      = 12,
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int VSYNC_W = 8,
  parameter int V_BP    = 16,
  parameter int H_BLANK = 32,
  parameter int V_FP    = 16
) (
  input  logic          CAM_pclk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] DP_RAM_addr_out,
  input  logic [DW-1:0] DP_RAM_data_out,
  output logic          CAM_vsync,
  output logic          CAM_href,
  output logic [7:0]    CAM_px_data,
  output logic          frame_done
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared in-state cycle counter covers every timed state, so it is sized
  // for the longest of them; within LINE its LSB doubles as the byte phase.
  localparam int CMAX = max_of(max_of(max_of(VSYNC_W, V_BP), max_of(2 * H_PIX, H_BLANK)), V_FP);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int LW   = $clog2(V_LINES + 1);

  localparam logic [CW-1:0] VS_LAST   = CW'(VSYNC_W - 1);
  localparam logic [CW-1:0] VBP_LAST  = CW'(V_BP - 1);
  localparam logic [CW-1:0] LN_LAST   = CW'(2 * H_PIX - 1);
  localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VFP_LAST  = CW'(V_FP - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_LINES - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(H_PIX * V_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLANK, S_VFP
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [LW-1:0]   line, line_d;
  logic [DW-1:0]   pix_q, pix_d;
  logic [AW-1:0]   addr_d;
  logic            vsync_d, href_d, done_d;
  logic [7:0]      px_d;
  logic            launch0;
  logic            start_frame;

  // Next-state and next-output decode; every output is registered from here.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    line_d      = line;
    pix_d       = pix_q;
    addr_d      = DP_RAM_addr_out;
    vsync_d     = 1'b0;
    href_d      = 1'b0;
    px_d        = 8'h00;
    done_d      = 1'b0;
    launch0     = 1'b0;
    start_frame = 1'b0;

    case (state)
      S_IDLE: begin
        if (en) start_frame = 1'b1;
      end
      S_VSYNC: begin
        if (cnt == VS_LAST) begin
          state_d = S_VBP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt + 1'b1;
          vsync_d = 1'b1;
        end
      end
      S_VBP: begin
        if (cnt == VBP_LAST) begin
          state_d = S_LINE;
          cnt_d   = '0;
          launch0 = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_LINE: begin
        if (cnt == LN_LAST) begin
          cnt_d = '0;
          if (line == LINE_LAST) begin
            state_d = S_VFP;
            line_d  = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_HBLANK;
            line_d  = line + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
          if (!cnt[0]) begin
            // Second byte of the pixel comes from the held register, not the RAM.
            href_d = 1'b1;
            px_d   = pix_q[7:0];
          end else begin
            launch0 = 1'b1;
          end
        end
      end
      S_HBLANK: begin
        if (cnt == HB_LAST) begin
          state_d = S_LINE;
          cnt_d   = '0;
          launch0 = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_VFP: begin
        if (cnt == VFP_LAST) begin
          cnt_d = '0;
          if (en) start_frame = 1'b1;
          else    state_d     = S_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_frame) begin
      state_d = S_VSYNC;
      cnt_d   = '0;
      line_d  = '0;
      vsync_d = 1'b1;
      addr_d  = '0;
    end

    // Phase-0 launch: emit R, latch the whole pixel, and move the address one
    // pixel ahead so the registered RAM has a full pixel time to respond.
    if (launch0) begin
      href_d = 1'b1;
      px_d   = {4'b0000, DP_RAM_data_out[11:8]};
      pix_d  = DP_RAM_data_out;
      addr_d = (DP_RAM_addr_out == ADDR_LAST) ? '0 : DP_RAM_addr_out + 1'b1;
    end
  end

  // State, counters and all outputs update together on the pixel clock.
  always_ff @(posedge CAM_pclk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      line            <= '0;
      pix_q           <= '0;
      DP_RAM_addr_out <= '0;
      CAM_vsync       <= 1'b0;
      CAM_href        <= 1'b0;
      CAM_px_data     <= 8'h00;
      frame_done      <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      line            <= line_d;
      pix_q           <= pix_d;
      DP_RAM_addr_out <= addr_d;
      CAM_vsync       <= vsync_d;
      CAM_href        <= href_d;
      CAM_px_data     <= px_d;
      frame_done      <= done_d;
    end
  end

endmodule

// File: tb/tb_cam_frame_tx.sv
// Directed bench for cam_frame_tx on a 4x2 frame with short blanking.
// Frame timeline from vsync rise (k=0): vsync 0..2, VBP 3..4, line0 5..12,
// hblank 13..15, line1 16..23, VFP 24..25 (frame_done at 24), period 26.
module tb_cam_frame_tx;

  localparam int AW = 4;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [AW-1:0] addr;
  logic [DW-1:0] ram_q = '0;
  logic          vsync, href, done;
  logic [7:0]    px;

  logic [DW-1:0] mem [16];

  int n_checks = 0;
  int n_pass   = 0;

  logic       cv [64];
  logic       ch [64];
  logic       cd [64];
  logic [7:0] cp [64];
  logic [3:0] ca [64];

  cam_frame_tx #(
    .AW(AW), .DW(DW), .H_PIX(4), .V_LINES(2),
    .VSYNC_W(3), .V_BP(2), .H_BLANK(3), .V_FP(2)
  ) dut (
    .CAM_pclk       (clk),
    .rst            (rst),
    .en             (en),
    .DP_RAM_addr_out(addr),
    .DP_RAM_data_out(ram_q),
    .CAM_vsync      (vsync),
    .CAM_href       (href),
    .CAM_px_data    (px),
    .frame_done     (done)
  );

  always #5 clk = ~clk;

  // Registered frame-buffer model: data follows the address by one edge.
  always @(posedge clk) ram_q <= mem[addr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Sample outputs at the current negedge and the n-1 following ones.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      cv[k] = vsync;
      ch[k] = href;
      cd[k] = done;
      cp[k] = px;
      ca[k] = addr;
    end
  endtask

  task automatic check_frame(input int off, input string tag);
    int vs_cnt, hr_cnt, dn_cnt, overlap, px_idle;
    int k;
    logic [7:0] exp_b;
    vs_cnt = 0; hr_cnt = 0; dn_cnt = 0; overlap = 0; px_idle = 0;
    for (int i = off; i < off + 26; i++) begin
      vs_cnt += int'(cv[i]);
      hr_cnt += int'(ch[i]);
      dn_cnt += int'(cd[i]);
      if (cv[i] && ch[i]) overlap++;
      if (!ch[i] && cp[i] != 8'h00) px_idle++;
    end
    check_val({tag, " vsync_at_start"}, 32'(cv[off]), 32'd1);
    check_val({tag, " addr_at_start"}, 32'(ca[off]), 32'd0);
    check_val({tag, " vsync_cycles"}, vs_cnt, 32'd3);
    check_val({tag, " href_cycles"}, hr_cnt, 32'd16);
    check_val({tag, " href0_edge"}, {ch[off+4], ch[off+5]}, 32'b01);
    check_val({tag, " href1_edge"}, {ch[off+15], ch[off+16]}, 32'b01);
    check_val({tag, " hblank"}, {ch[off+12], ch[off+13], ch[off+15]}, 32'b100);
    check_val({tag, " done_count"}, dn_cnt, 32'd1);
    check_val({tag, " done_pos"}, 32'(cd[off+24]), 32'd1);
    check_val({tag, " vsync_href_overlap"}, overlap, 32'd0);
    check_val({tag, " px_zero_when_idle"}, px_idle, 32'd0);
    check_val({tag, " addr_mid_line1"}, 32'(ca[off+20]), 32'd7);
    check_val({tag, " addr_wrap"}, 32'(ca[off+22]), 32'd0);
    for (int b = 0; b < 16; b++) begin
      k = off + 5 + b + ((b >= 8) ? 3 : 0);
      exp_b = (b % 2 == 0) ? 8'(b / 2) : 8'hAB;
      check_val($sformatf("%s byte%0d", tag, b), 32'(cp[k]), 32'(exp_b));
    end
  endtask

  initial begin
    int busy;
    for (int i = 0; i < 16; i++) mem[i] = 12'((i << 8) + 'hAB);

    // Reset and idle with en low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_outputs", {vsync, href, done, px, addr}, 32'd0);
    rst = 1'b0;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vsync || href || done || px != 8'h00 || addr != '0) busy++;
    end
    check_val("idle_active_cycles", busy, 32'd0);

    // Single frame; en dropped right after start must not abort it.
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    @(negedge clk);
    capture(40);
    check_frame(0, "f1");
    busy = 0;
    for (int i = 26; i < 40; i++) busy += int'(cv[i]) + int'(ch[i]);
    check_val("f1_no_restart", busy, 32'd0);
    check_val("f1_idle_addr", 32'(ca[39]), 32'd0);

    // en held: frames run back to back with a 26-cycle vsync period.
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    capture(60);
    check_frame(0, "b2b_a");
    check_frame(26, "b2b_b");
    check_val("b2b_vsync_period", {cv[25], cv[26]}, 32'b01);
    en = 1'b0;
    repeat (40) @(negedge clk);
    check_val("b2b_back_idle", {vsync, href, done}, 32'd0);

    // Reset in the middle of line 0, then restart from pixel 0.
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    repeat (7) @(negedge clk);
    check_val("rst_mid_in_line", 32'(href), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_mid_outputs", {vsync, href, done, px, addr}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    capture(30);
    check_frame(0, "restart");
    en = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
